// File: rtl/keypad_entry_pkg.sv
// rtl/keypad_entry_pkg.sv - shared key codes, state enum and key decode helper for keypad_entry
package keypad_entry_pkg;

    localparam logic [3:0] KEY_BACK = 4'hA;
    localparam logic [3:0] KEY_CLR  = 4'hB;
    localparam logic [3:0] KEY_ENT  = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTRY   = 2'd1,
        ST_CONVERT = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - key event input and entry/result outputs of keypad_entry
interface keypad_entry_if #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
);
    localparam int LEN_W = $clog2(DIGITS + 1);

    logic                  key_en;
    logic [3:0]            key_code;
    logic [4*DIGITS-1:0]   entry_bcd;
    logic [LEN_W-1:0]      entry_len;
    logic                  busy;
    logic                  value_valid;
    logic [BIN_W-1:0]      value;
    logic [4*DIGITS-1:0]   value_bcd;
    logic                  overflow;
    logic                  timeout;

    // Scanner / application side
    modport master (
        output key_en, key_code,
        input  entry_bcd, entry_len, busy, value_valid, value, value_bcd, overflow, timeout
    );

    // keypad_entry side
    modport slave (
        input  key_en, key_code,
        output entry_bcd, entry_len, busy, value_valid, value, value_bcd, overflow, timeout
    );

endinterface

// File: rtl/counter.sv
// rtl/counter.sv - free-running up counter with synchronous clear and enable
module counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Clear has priority over counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/keypad_entry_bcd_to_bin_seq.sv
// rtl/keypad_entry_bcd_to_bin_seq.sv - sequential BCD to binary converter, one digit per cycle
module bcd_to_bin_seq
    import keypad_entry_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] bcd_in,
    output logic                busy,
    output logic                last,
    output logic                done,
    output logic [BIN_W-1:0]    result,
    output logic [4*DIGITS-1:0] result_bcd
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [4*DIGITS-1:0] work;
    logic [4*DIGITS-1:0] bcd_hold;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc_next;
    logic [IDX_W-1:0]    idx;

    // acc*10 as shift-add, truncated to BIN_W; the MS digit sits at the top of work
    assign acc_next = (acc << 3) + (acc << 1) + {{(BIN_W-4){1'b0}}, work[4*DIGITS-1 -: 4]};

    // Flags the cycle consuming the final digit so the caller can leave its wait state in step
    assign last = busy && (idx == IDX_LAST);

    // Load on start, then fold one digit per cycle and publish result on the last one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            work       <= '0;
            bcd_hold   <= '0;
            acc        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            result_bcd <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                work     <= bcd_in;
                bcd_hold <= bcd_in;
                acc      <= '0;
                idx      <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                acc  <= acc_next;
                work <= work << 4;
                idx  <= idx + 1'b1;
                if (last) begin
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    result     <= acc_next;
                    result_bcd <= bcd_hold;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - assembles keypad events into a BCD entry and commits it as a binary value
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DIGITS  = 4,
    parameter int BIN_W   = 14,
    parameter int TIMEOUT = 50000000
) (
    input  logic          clk,
    input  logic          reset_n,
    keypad_entry_if.slave bus
);

    localparam int ENTRY_W = 4 * DIGITS;
    localparam int LEN_W   = $clog2(DIGITS + 1);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DIGITS);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic             TMO_ON   = (TIMEOUT > 0);

    state_t               state;
    logic                 pending;
    logic                 key_vld;
    logic [3:0]           code_q;
    logic [ENTRY_W-1:0]   entry_q;
    logic [LEN_W-1:0]     len_q;
    logic                 ovf_q;
    logic                 tmo_q;

    logic                 conv_start;
    logic                 conv_busy;
    logic                 conv_last;
    logic                 conv_done;
    logic [BIN_W-1:0]     conv_result;
    logic [ENTRY_W-1:0]   conv_bcd;

    logic [CNT_W-1:0]     idle_cnt;
    logic                 key_act;
    logic                 tmo_hit;
    logic                 cnt_clr;

    assign key_act    = key_vld && (state != ST_CONVERT);
    assign conv_start = key_vld && (code_q == KEY_ENT) && (state == ST_ENTRY);
    assign tmo_hit    = TMO_ON && (state == ST_ENTRY) && (idle_cnt == TMO_LAST);
    assign cnt_clr    = key_act || (state != ST_ENTRY) || tmo_hit;

    // Two-stage key capture: flag the event, then grab the code on the following cycle.
    // Anything in flight while converting (or as conversion starts) is thrown away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= 1'b0;
            key_vld <= 1'b0;
            code_q  <= '0;
        end else if ((state == ST_CONVERT) || conv_start) begin
            pending <= 1'b0;
            key_vld <= 1'b0;
        end else begin
            key_vld <= pending;
            pending <= bus.key_en && !pending;
            if (pending) begin
                code_q <= bus.key_code;
            end
        end
    end

    // Entry editing, commit and auto-clear state machine
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            entry_q <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
            case (state)
                ST_IDLE, ST_ENTRY: begin
                    if (key_vld) begin
                        if (is_digit(code_q)) begin
                            if (len_q < LEN_MAX) begin
                                entry_q <= (entry_q << 4) | ENTRY_W'(code_q);
                                len_q   <= len_q + 1'b1;
                                state   <= ST_ENTRY;
                            end else begin
                                ovf_q <= 1'b1;
                            end
                        end else if (code_q == KEY_BACK) begin
                            if (len_q != '0) begin
                                entry_q <= entry_q >> 4;
                                len_q   <= len_q - 1'b1;
                                state   <= (len_q == LEN_ONE) ? ST_IDLE : ST_ENTRY;
                            end
                        end else if (code_q == KEY_CLR) begin
                            entry_q <= '0;
                            len_q   <= '0;
                            state   <= ST_IDLE;
                        end else if (conv_start) begin
                            state <= ST_CONVERT;
                        end
                    end else if (tmo_hit) begin
                        entry_q <= '0;
                        len_q   <= '0;
                        tmo_q   <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                ST_CONVERT: begin
                    if (conv_last) begin
                        entry_q <= '0;
                        len_q   <= '0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    counter #(
        .WIDTH (CNT_W)
    ) u_idle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (state == ST_ENTRY),
        .count   (idle_cnt)
    );

    bcd_to_bin_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (conv_start),
        .bcd_in     (entry_q),
        .busy       (conv_busy),
        .last       (conv_last),
        .done       (conv_done),
        .result     (conv_result),
        .result_bcd (conv_bcd)
    );

    assign bus.entry_bcd   = entry_q;
    assign bus.entry_len   = len_q;
    assign bus.busy        = conv_busy;
    assign bus.value_valid = conv_done;
    assign bus.value       = conv_result;
    assign bus.value_bcd   = conv_bcd;
    assign bus.overflow    = ovf_q;
    assign bus.timeout     = tmo_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - directed self-checking bench for keypad_entry
module tb_keypad_entry;
    import keypad_entry_pkg::*;

    localparam int DIGITS  = 4;
    localparam int BIN_W   = 14;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    keypad_entry_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus();

    keypad_entry #(
        .DIGITS  (DIGITS),
        .BIN_W   (BIN_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total  = 0;
    int passed = 0;
    int failed = 0;
    logic seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse key_en for one cycle, hold the code for the capture cycle, return once the key has taken effect
    task automatic send_key(input logic [3:0] c);
        @(negedge clk);
        bus.key_en   = 1'b1;
        bus.key_code = c;
        @(negedge clk);
        bus.key_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.key_en   = 1'b0;
        bus.key_code = 4'h0;
        cyc(3);
        check("rst_entry_bcd", bus.entry_bcd, 32'h0);
        check("rst_entry_len", bus.entry_len, 32'h0);
        check("rst_busy", bus.busy, 32'h0);
        check("rst_value_valid", bus.value_valid, 32'h0);
        check("rst_value", bus.value, 32'h0);
        check("rst_value_bcd", bus.value_bcd, 32'h0);
        check("rst_overflow", bus.overflow, 32'h0);
        check("rst_timeout", bus.timeout, 32'h0);
        reset_n = 1'b1;
        cyc(2);

        // 1,2,3,4,enter
        send_key(4'h1);
        check("t1_first_bcd", bus.entry_bcd, 32'h1);
        check("t1_first_len", bus.entry_len, 32'd1);
        send_key(4'h2);
        send_key(4'h3);
        send_key(4'h4);
        check("t1_bcd", bus.entry_bcd, 32'h1234);
        check("t1_len", bus.entry_len, 32'd4);
        send_key(KEY_ENT);
        check("t1_busy_start", bus.busy, 32'h1);
        check("t1_bcd_held", bus.entry_bcd, 32'h1234);
        cyc(3);
        check("t1_busy_end", bus.busy, 32'h1);
        check("t1_no_early_valid", bus.value_valid, 32'h0);
        cyc(1);
        check("t1_valid", bus.value_valid, 32'h1);
        check("t1_value", bus.value, 32'h4D2);
        check("t1_value_bcd", bus.value_bcd, 32'h1234);
        check("t1_busy_low", bus.busy, 32'h0);
        check("t1_entry_clr", bus.entry_bcd, 32'h0);
        check("t1_len_clr", bus.entry_len, 32'h0);
        cyc(1);
        check("t1_valid_pulse", bus.value_valid, 32'h0);
        check("t1_value_hold", bus.value, 32'h4D2);

        // 9,9,9,9,5 then enter
        send_key(4'h9);
        send_key(4'h9);
        send_key(4'h9);
        send_key(4'h9);
        check("t2_no_ovf_at_full", bus.overflow, 32'h0);
        send_key(4'h5);
        check("t2_overflow", bus.overflow, 32'h1);
        check("t2_bcd", bus.entry_bcd, 32'h9999);
        check("t2_len", bus.entry_len, 32'd4);
        cyc(1);
        check("t2_ovf_pulse", bus.overflow, 32'h0);
        send_key(KEY_ENT);
        cyc(4);
        check("t2_valid", bus.value_valid, 32'h1);
        check("t2_value", bus.value, 32'h270F);
        check("t2_value_bcd", bus.value_bcd, 32'h9999);

        // 7, backspace, backspace, enter
        send_key(4'h7);
        check("t3_len1", bus.entry_len, 32'd1);
        check("t3_bcd7", bus.entry_bcd, 32'h7);
        send_key(KEY_BACK);
        check("t3_len0", bus.entry_len, 32'd0);
        check("t3_bcd0", bus.entry_bcd, 32'h0);
        send_key(KEY_BACK);
        check("t3_back_noop_len", bus.entry_len, 32'd0);
        send_key(KEY_ENT);
        check("t3_enter_ignored_busy", bus.busy, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            seen = seen | bus.value_valid;
        end
        check("t3_no_valid", seen, 32'h0);
        check("t3_value_kept", bus.value, 32'h270F);

        // 4,2 then idle until timeout
        send_key(4'h4);
        send_key(4'h2);
        check("t4_bcd", bus.entry_bcd, 32'h42);
        seen = 1'b0;
        for (int i = 0; i < 99; i++) begin
            cyc(1);
            seen = seen | bus.timeout;
        end
        check("t4_no_early_timeout", seen, 32'h0);
        check("t4_bcd_before_timeout", bus.entry_bcd, 32'h42);
        cyc(1);
        check("t4_timeout", bus.timeout, 32'h1);
        check("t4_bcd_cleared", bus.entry_bcd, 32'h0);
        check("t4_len_cleared", bus.entry_len, 32'h0);
        check("t4_value_kept", bus.value, 32'h270F);
        cyc(1);
        check("t4_timeout_pulse", bus.timeout, 32'h0);

        // 5, enter, key 3 while busy
        send_key(4'h5);
        send_key(KEY_ENT);
        check("t5_busy", bus.busy, 32'h1);
        bus.key_en   = 1'b1;
        bus.key_code = 4'h3;
        cyc(1);
        bus.key_en = 1'b0;
        cyc(2);
        check("t5_still_busy", bus.busy, 32'h1);
        cyc(1);
        check("t5_valid", bus.value_valid, 32'h1);
        check("t5_value", bus.value, 32'h5);
        check("t5_value_bcd", bus.value_bcd, 32'h5);
        cyc(3);
        check("t5_key_discarded_bcd", bus.entry_bcd, 32'h0);
        check("t5_key_discarded_len", bus.entry_len, 32'h0);

        // reset during conversion of 0x0042
        send_key(4'h4);
        send_key(4'h2);
        send_key(KEY_ENT);
        check("t6_busy", bus.busy, 32'h1);
        cyc(1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_busy", bus.busy, 32'h0);
        check("t6_rst_value", bus.value, 32'h0);
        check("t6_rst_value_bcd", bus.value_bcd, 32'h0);
        check("t6_rst_entry", bus.entry_bcd, 32'h0);
        check("t6_rst_len", bus.entry_len, 32'h0);
        check("t6_rst_valid", bus.value_valid, 32'h0);
        cyc(2);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            seen = seen | bus.value_valid;
        end
        check("t6_no_valid", seen, 32'h0);
        check("t6_value_zero", bus.value, 32'h0);
        check("t6_busy_low", bus.busy, 32'h0);
        send_key(4'h8);
        check("t6_idle_accepts_bcd", bus.entry_bcd, 32'h8);
        check("t6_idle_accepts_len", bus.entry_len, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
